axis_beat_serializer: RTL and testbench



---
 rtl/axis_beat_serializer.sv | 105 ++++++++++
 tb/tb_axis_beat_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_beat_serializer.sv
`default_nettype none
// ============================================================================
// Module  : axis_beat_serializer
// Brief   : Splits one wide AXIS word into LSB-first link beats with index/last
// Revision: 1.0
// ============================================================================

module axis_beat_serializer #(
  parameter int unsigned PayloadWidth = 65,
  parameter int unsigned BeatWidth    = 16,
  // Derived from the two widths above; leave at their defaults.
  parameter int unsigned NumBeats     = (PayloadWidth + BeatWidth - 1) / BeatWidth,
  parameter int unsigned CntWidth     = (NumBeats > 1) ? $clog2(NumBeats) : 1,
  parameter bit          IgnoreAssert = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PayloadWidth-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [BeatWidth-1:0]    out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_last_o,
  output logic [CntWidth-1:0]     out_idx_o,
  output logic                    busy_o
);

  localparam int unsigned         BufWidth = NumBeats * BeatWidth;
  localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(NumBeats - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  logic [BufWidth-1:0] buf_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                ready_en_q;
  logic                in_hs;
  logic                out_hs;

  // ready_en_q keeps tready low until the first cycle after reset releases.
  assign in_ready_o = ready_en_q &
                      ((state_q == IDLE) | ((state_q == SEND) & out_last_q & out_ready_i));
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_q & out_ready_i;
  assign cnt_d      = cnt_q + CntWidth'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (in_hs) begin
        // Covers both a load from IDLE and a back-to-back reload on the last beat.
        state_q     <= SEND;
        buf_q       <= BufWidth'(in_data_i);
        cnt_q       <= '0;
        out_valid_q <= 1'b1;
        out_last_q  <= (LastIdx == '0);
      end else if (out_hs) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          buf_q       <= '0;
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          buf_q      <= buf_q >> BeatWidth;
          cnt_q      <= cnt_d;
          out_last_q <= (cnt_d == LastIdx);
        end
      end
    end
  end

  assign out_data_o  = buf_q[BeatWidth-1:0];
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_idx_o   = cnt_q;
  assign busy_o      = (state_q == SEND);

  a_data_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni || IgnoreAssert)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o))
  );

  a_cnt_range : assert property (
    @(posedge clk_i) disable iff (!rst_ni || IgnoreAssert)
    (cnt_q <= LastIdx)
  );

endmodule

`default_nettype wire

// File: tb/tb_axis_beat_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_beat_serializer
// Brief   : Directed + random checks of three serializer configurations
// Revision: 1.0
// ============================================================================

module tb_axis_beat_serializer;

  localparam int NB_A = (40 + 15) / 16;
  localparam int NB_B = (65 + 15) / 16;
  localparam int NB_C = (16 + 15) / 16;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [39:0] in_a;  logic val_a, rdy_a, ordy_a, ov_a, ol_a, busy_a;
  logic [15:0] od_a;  logic [1:0] oi_a;
  logic [64:0] in_b;  logic val_b, rdy_b, ordy_b, ov_b, ol_b, busy_b;
  logic [15:0] od_b;  logic [2:0] oi_b;
  logic [15:0] in_c;  logic val_c, rdy_c, ordy_c, ov_c, ol_c, busy_c;
  logic [15:0] od_c;  logic [0:0] oi_c;

  axis_beat_serializer #(.PayloadWidth(40), .BeatWidth(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_a), .in_valid_i(val_a), .in_ready_o(rdy_a),
    .out_data_o(od_a), .out_valid_o(ov_a), .out_ready_i(ordy_a), .out_last_o(ol_a),
    .out_idx_o(oi_a), .busy_o(busy_a));

  axis_beat_serializer u_b (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_b), .in_valid_i(val_b), .in_ready_o(rdy_b),
    .out_data_o(od_b), .out_valid_o(ov_b), .out_ready_i(ordy_b), .out_last_o(ol_b),
    .out_idx_o(oi_b), .busy_o(busy_b));

  axis_beat_serializer #(.PayloadWidth(16), .BeatWidth(16)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_c), .in_valid_i(val_c), .in_ready_o(rdy_c),
    .out_data_o(od_c), .out_valid_o(ov_c), .out_ready_i(ordy_c), .out_last_o(ol_c),
    .out_idx_o(oi_c), .busy_o(busy_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic [15:0] d,
                       input int i, input logic l);
    @(negedge clk);
    chk({tag, "_valid"}, ov_a, v);
    if (v) begin
      chk({tag, "_data"}, od_a, d);
      chk({tag, "_idx"},  oi_a, i);
      chk({tag, "_last"}, ol_a, l);
    end
  endtask

  // Reference model: each accepted word becomes a queue of expected beats.
  beat_t qa[$], qb[$], qc[$];
  beat_t hold_a, hold_b, hold_c, e;
  logic  stall_a = 0, stall_b = 0, stall_c = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); stall_a = 0;
    end else begin
      if (stall_a) begin
        chk("a_hold_valid", ov_a, 1'b1);
        chk("a_hold_beat", {od_a, 1'b0, oi_a, ol_a}, hold_a);
      end
      if (ov_a && ordy_a) begin
        if (qa.size() == 0) chk("a_unexpected_beat", ov_a, 1'b0);
        else begin e = qa.pop_front(); chk("a_beat", {od_a, 1'b0, oi_a, ol_a}, e); end
      end
      if (val_a && rdy_a)
        for (int k = 0; k < NB_A; k++) qa.push_back({16'(in_a >> (16*k)), 3'(k), k == NB_A-1});
      stall_a = ov_a && !ordy_a;
      hold_a  = {od_a, 1'b0, oi_a, ol_a};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete(); stall_b = 0;
    end else begin
      if (stall_b) begin
        chk("b_hold_valid", ov_b, 1'b1);
        chk("b_hold_beat", {od_b, oi_b, ol_b}, hold_b);
      end
      if (ov_b && ordy_b) begin
        if (qb.size() == 0) chk("b_unexpected_beat", ov_b, 1'b0);
        else begin e = qb.pop_front(); chk("b_beat", {od_b, oi_b, ol_b}, e); end
      end
      if (val_b && rdy_b)
        for (int k = 0; k < NB_B; k++) qb.push_back({16'(in_b >> (16*k)), 3'(k), k == NB_B-1});
      stall_b = ov_b && !ordy_b;
      hold_b  = {od_b, oi_b, ol_b};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qc.delete(); stall_c = 0;
    end else begin
      if (stall_c) begin
        chk("c_hold_valid", ov_c, 1'b1);
        chk("c_hold_beat", {od_c, 2'b00, oi_c, ol_c}, hold_c);
      end
      if (ov_c && ordy_c) begin
        if (qc.size() == 0) chk("c_unexpected_beat", ov_c, 1'b0);
        else begin e = qc.pop_front(); chk("c_beat", {od_c, 2'b00, oi_c, ol_c}, e); end
      end
      if (val_c && rdy_c)
        for (int k = 0; k < NB_C; k++) qc.push_back({16'(in_c >> (16*k)), 3'(k), k == NB_C-1});
      stall_c = ov_c && !ordy_c;
      hold_c  = {od_c, 2'b00, oi_c, ol_c};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [39:0] w;
  logic        got, hsa, hsb, hsc;

  initial begin
    rst_n = 0;
    val_a = 0; val_b = 0; val_c = 0;
    in_a = '0; in_b = '0; in_c = '0;
    ordy_a = 1; ordy_b = 1; ordy_c = 1;
    step(); step();

    // Reset values
    @(negedge clk);
    chk("rst_a_valid", ov_a, 1'b0);  chk("rst_a_busy", busy_a, 1'b0);
    chk("rst_a_data", od_a, 16'h0);  chk("rst_a_idx", oi_a, 2'd0);
    chk("rst_a_last", ol_a, 1'b0);   chk("rst_b_valid", ov_b, 1'b0);
    chk("rst_c_busy", busy_c, 1'b0);
    step();
    rst_n = 1;
    step();
    @(negedge clk);
    chk("rst_a_ready_after", rdy_a, 1'b1);

    // Single word, full throughput
    step();
    val_a = 1; in_a = 40'hAB_CDEF_1234;
    @(negedge clk);
    chk("t1_ready_idle", rdy_a, 1'b1);
    step();
    val_a = 0;
    exp_a("t1_b0", 1, 16'h1234, 0, 0); chk("t1_rdy_b0", rdy_a, 1'b0); step();
    exp_a("t1_b1", 1, 16'hCDEF, 1, 0); chk("t1_rdy_b1", rdy_a, 1'b0); step();
    exp_a("t1_b2", 1, 16'h00AB, 2, 1); chk("t1_rdy_b2", rdy_a, 1'b1); step();
    exp_a("t1_idle", 0, 0, 0, 0);      chk("t1_busy", busy_a, 1'b0);

    // Back-to-back words
    step();
    val_a = 1; in_a = 40'h11_2222_3333;
    step();
    in_a = 40'h44_5555_6666;
    exp_a("t2_b0", 1, 16'h3333, 0, 0); step();
    exp_a("t2_b1", 1, 16'h2222, 1, 0); step();
    exp_a("t2_b2", 1, 16'h0011, 2, 1); chk("t2_rdy_b2b", rdy_a, 1'b1); step();
    val_a = 0;
    exp_a("t2_b3", 1, 16'h6666, 0, 0); step();
    exp_a("t2_b4", 1, 16'h5555, 1, 0); step();
    exp_a("t2_b5", 1, 16'h0044, 2, 1); step();
    exp_a("t2_idle", 0, 0, 0, 0);

    // Backpressure on beat 1
    step();
    val_a = 1; in_a = 40'hAB_CDEF_1234;
    step();
    val_a = 0;
    exp_a("t3_b0", 1, 16'h1234, 0, 0); step();
    ordy_a = 0;
    for (int i = 0; i < 3; i++) begin
      exp_a("t3_stall", 1, 16'hCDEF, 1, 0);
      step();
    end
    ordy_a = 1;
    exp_a("t3_b1", 1, 16'hCDEF, 1, 0); step();
    exp_a("t3_b2", 1, 16'h00AB, 2, 1); step();
    exp_a("t3_idle", 0, 0, 0, 0);

    // Reset mid-word
    step();
    val_a = 1; in_a = 40'hAB_CDEF_1234;
    step();
    val_a = 0;
    exp_a("t4_b0", 1, 16'h1234, 0, 0); step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("t4_valid_after_rst", ov_a, 1'b0);
    chk("t4_busy_after_rst", busy_a, 1'b0);
    w = 40'({$urandom(), $urandom()});
    val_a = 1; in_a = w;
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      got = rdy_a;
      step();
    end
    chk("t4_ready_seen", got, 1'b1);
    val_a = 0;
    for (int k = 0; k < NB_A; k++) begin
      exp_a("t4_fresh", 1, 16'(w >> (16*k)), k, k == NB_A-1);
      step();
    end

    // Default config: header bit plus all-ones flit
    val_b = 1; in_b = {1'b1, {64{1'b1}}};
    @(negedge clk);
    chk("t5_ready", rdy_b, 1'b1);
    step();
    val_b = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_ff_beat", {ov_b, od_b, oi_b, ol_b}, {1'b1, 16'hFFFF, 3'(k), 1'b0});
      step();
    end
    @(negedge clk);
    chk("t5_hdr_beat", {ov_b, od_b, oi_b, ol_b}, {1'b1, 16'h0001, 3'd4, 1'b1});
    step();

    // Single-beat config streams one word per cycle
    val_c = 1;
    for (int i = 1; i <= 8; i++) begin
      in_c = 16'(i);
      @(negedge clk);
      chk("t6_ready", rdy_c, 1'b1);
      if (i > 1) chk("t6_beat", {ov_c, od_c, oi_c, ol_c}, {1'b1, 16'(i-1), 1'b0, 1'b1});
      step();
    end
    val_c = 0;
    @(negedge clk);
    chk("t6_beat_last", {ov_c, od_c, oi_c, ol_c}, {1'b1, 16'h0008, 1'b0, 1'b1});
    step();

    // Random traffic with random backpressure on all three instances
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      hsa = val_a & rdy_a; hsb = val_b & rdy_b; hsc = val_c & rdy_c;
      step();
      if (!val_a || hsa) begin val_a = 1'($urandom()); in_a = 40'({$urandom(), $urandom()}); end
      if (!val_b || hsb) begin
        val_b = 1'($urandom()); in_b = 65'({$urandom(), $urandom(), $urandom()});
      end
      if (!val_c || hsc) begin val_c = 1'($urandom()); in_c = 16'($urandom()); end
      ordy_a = ($urandom_range(3) != 0);
      ordy_b = ($urandom_range(3) != 0);
      ordy_c = ($urandom_range(3) != 0);
    end

    // Drain: every accepted word must have been fully emitted
    @(negedge clk);
    step();
    val_a = 0; val_b = 0; val_c = 0;
    ordy_a = 1; ordy_b = 1; ordy_c = 1;
    repeat (20) step();
    @(negedge clk);
    chk("drain_a_pending", qa.size(), 0); chk("drain_a_valid", ov_a, 1'b0);
    chk("drain_b_pending", qb.size(), 0); chk("drain_b_valid", ov_b, 1'b0);
    chk("drain_c_pending", qc.size(), 0); chk("drain_c_valid", ov_c, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
